multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter SEL_W, default 3: width of alu_src_a, alu_src_b, result_src.
REQ-002 Parameter ALUOP_W, default 2 (minimum 2): width of alu_op.
REQ-003 Parameter TIMEOUT, default 16 (minimum 2): maximum memory wait cycles before a bus-fault trap.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- op  in  7  opcode.
- funct3  in  3  funct3 field.
- funct7_0  in  1  instruction bit 25.
- mem_ready  in  1  memory handshake complete.
- md_done  in  1  multiply/divide unit done.
- pc_write, ir_write, pc_src, reg_write, imm, mem_write, branch  out  1 each  datapath strobes.
- mem_req  out  1  memory access request.
- md_start  out  1  multiply/divide start pulse.
- adr_src  out  2  address select: 00 PC, 01 ALUOut.
- alu_op  out  ALUOP_W  ALU operation: 0 add, 1 compare, 2 funct-decoded.
- alu_src_a  out  SEL_W  A-operand select: 1 rs1, 2 oldPC, 3 zero.
- alu_src_b  out  SEL_W  B-operand select: 0 rs2, 1 constant 4, 2 immediate.
- result_src  out  SEL_W  writeback select: 0 ALUOut, 1 read data, 2 ALUResult, 3 md result.
- halt  out  1  core halted in TRAP.
- trap_cause  out  2  0 illegal opcode, 1 EBREAK/ECALL, 2 bus timeout.
- state_o  out  4  current state encoding, for debug.

Function
REQ-005 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWR 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, JALR 11, AUIPC 12, LUI 13, TRAP 14, MULDIV 15.
REQ-006 All outputs are combinational from state, mem_ready and md_done; the only registers are state, the wait counter, and trap_cause.
REQ-007 Any output not asserted by a state in REQ-008..REQ-017 is 0.
REQ-008 FETCH: mem_req=1, alu_src_b=1; ir_write and pc_write are 1 only in the cycle mem_ready=1, and the FSM then goes to DECODE; otherwise it stays in FETCH.
REQ-009 DECODE: alu_src_a=2, alu_src_b=2.
REQ-010 DECODE next state by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1101111 -> JAL.
- 1100011 -> BRANCH.
- 1100111 -> JALR.
- 0010111 -> AUIPC.
- 0110111 -> LUI.
- 1110011 -> TRAP with cause 1.
- any other opcode -> TRAP with cause 0.
REQ-011 MEMADR: alu_src_a=1, alu_src_b=2; next state is MEMREAD for a load, MEMWR for a store.
REQ-012 MEMREAD: adr_src=1, mem_req=1; goes to MEMWB on mem_ready, else holds.
REQ-013 MEMWR: adr_src=1, mem_req=1, mem_write=1; goes to FETCH on mem_ready, else holds. mem_write stays asserted throughout the wait.
REQ-014 MEMWB: reg_write=1, result_src=1, then FETCH. ALUWB: reg_write=1, then FETCH.
REQ-015 EXECR: alu_src_a=1, alu_op=2, then ALUWB. EXECI: the same plus alu_src_b=2, imm=1, then ALUWB.
REQ-016 JAL: alu_src_a=2, alu_src_b=1, pc_write=1, reg_write=1, result_src=2, then FETCH.
REQ-017 Remaining states:
- BRANCH: alu_src_a=1, alu_op=1, branch=1, pc_src=1, then FETCH.
- JALR: alu_src_a=2, alu_src_b=1, pc_write=1, pc_src=1, imm=1, then ALUWB.
- AUIPC: alu_src_a=2, alu_src_b=2, then ALUWB.
- LUI: alu_src_a=3, alu_src_b=2, then ALUWB.
REQ-018 Wait counter behaviour:
- Clears on every state change.
- Increments each cycle spent in FETCH, MEMREAD or MEMWR with mem_ready=0.
- When it reaches TIMEOUT-1 with mem_ready still 0, the next state is TRAP with cause 2.
- mem_ready=1 in that same cycle wins: normal transition, no trap.
REQ-019 TRAP: halt=1; trap_cause is held; the FSM stays in TRAP until reset; all strobes are 0.
REQ-020 Unused high bits of any SEL_W- or ALUOP_W-wide output are 0.

Reset
REQ-021 When resetn=0 at a rising clk edge: state becomes FETCH, the wait counter becomes 0, and trap_cause becomes 0, in any state including mid-wait and TRAP.
REQ-022 During and after reset the outputs equal the FETCH decode: mem_req=1, alu_src_b=1, and all other outputs 0 unless mem_ready=1.

Configuration
REQ-023 Macro CTRL_MULDIV_EN defined:
- In DECODE, op=0110011 with funct7_0=1 goes to MULDIV.
- MULDIV asserts md_start for its first cycle only.
- MULDIV holds until md_done=1, then goes to ALUWB with result_src=3 in the ALUWB cycle.
REQ-024 Macro CTRL_MULDIV_EN undefined:
- No MULDIV state; md_start is tied to 0.
- op=0110011 goes to EXECR regardless of funct7_0.
- md_done is ignored.

Verification
REQ-025 Add instruction, mem_ready=1 at all times -> FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in cycle 4.
REQ-026 Load with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src=1, then FETCH.
REQ-027 TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles in FETCH; halt=1, trap_cause=2; held until resetn=0, after which state_o=0.
REQ-028 op=1110011 -> TRAP with trap_cause=1; op=1111111 -> TRAP with trap_cause=0; halt stays 1 for 20 cycles.
REQ-029 With CTRL_MULDIV_EN, op=0110011 and funct7_0=1, md_done raised after 5 cycles -> md_start pulses for exactly 1 cycle, then ALUWB with result_src=3. Without the macro, the same instruction goes through EXECR.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM with memory-wait timeout and trap handling.
// Optional multiply/divide sequencing is enabled by defining CTRL_MULDIV_EN.
module multicycle_ctrl #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned ALUOP_W = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7_0,
    input  logic               mem_ready,
    input  logic               md_done,
    output logic               pc_write,
    output logic               ir_write,
    output logic               pc_src,
    output logic               reg_write,
    output logic               imm,
    output logic               mem_write,
    output logic               branch,
    output logic               mem_req,
    output logic               md_start,
    output logic [1:0]         adr_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [SEL_W-1:0]   alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   result_src,
    output logic               halt,
    output logic [1:0]         trap_cause,
    output logic [3:0]         state_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_ALUWB   = 4'd7,
        S_EXECI   = 4'd8,
        S_JAL     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JALR    = 4'd11,
        S_AUIPC   = 4'd12,
        S_LUI     = 4'd13,
`ifdef CTRL_MULDIV_EN
        S_TRAP    = 4'd14,
        S_MULDIV  = 4'd15
`else
        S_TRAP    = 4'd14
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       cause;
    logic             timed_out;

    assign timed_out  = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign state_o    = state;
    assign trap_cause = cause;

`ifdef CTRL_MULDIV_EN
    logic unused_ok;
    assign unused_ok = ^funct3;
`else
    logic unused_ok;
    assign unused_ok = ^{funct3, funct7_0, md_done};
`endif

    // wait_cnt clears by default; only the wait states override it.
    // In MULDIV/ALUWB a nonzero count marks "not first cycle" / "md result".
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause    <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_FETCH, S_MEMREAD, S_MEMWR: begin
                    if (mem_ready) begin
                        state <= (state == S_FETCH)   ? S_DECODE :
                                 (state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
                    end else if (timed_out) begin
                        state <= S_TRAP;
                        cause <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    case (op)
                        7'b0000011, 7'b0100011: state <= S_MEMADR;
`ifdef CTRL_MULDIV_EN
                        7'b0110011: state <= funct7_0 ? S_MULDIV : S_EXECR;
`else
                        7'b0110011: state <= S_EXECR;
`endif
                        7'b0010011: state <= S_EXECI;
                        7'b1101111: state <= S_JAL;
                        7'b1100011: state <= S_BRANCH;
                        7'b1100111: state <= S_JALR;
                        7'b0010111: state <= S_AUIPC;
                        7'b0110111: state <= S_LUI;
                        7'b1110011: begin
                            state <= S_TRAP;
                            cause <= 2'd1;
                        end
                        default: begin
                            state <= S_TRAP;
                            cause <= 2'd0;
                        end
                    endcase
                end
                S_MEMADR: state <= (op == 7'b0100011) ? S_MEMWR : S_MEMREAD;
                S_MEMWB, S_ALUWB, S_JAL, S_BRANCH: state <= S_FETCH;
                S_EXECR, S_EXECI, S_JALR, S_AUIPC, S_LUI: state <= S_ALUWB;
                S_TRAP: state <= S_TRAP;
`ifdef CTRL_MULDIV_EN
                S_MULDIV: begin
                    wait_cnt <= CNT_W'(1);
                    if (md_done) state <= S_ALUWB;
                end
`endif
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        imm        = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        mem_req    = 1'b0;
        md_start   = 1'b0;
        halt       = 1'b0;
        adr_src    = '0;
        alu_op     = '0;
        alu_src_a  = '0;
        alu_src_b  = '0;
        result_src = '0;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SEL_W'(1);
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SEL_W'(2);
                alu_src_b = SEL_W'(2);
            end
            S_MEMADR: begin
                alu_src_a = SEL_W'(1);
                alu_src_b = SEL_W'(2);
            end
            S_MEMREAD: begin
                adr_src = 2'd1;
                mem_req = 1'b1;
            end
            S_MEMWR: begin
                adr_src   = 2'd1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = SEL_W'(1);
            end
            S_ALUWB: begin
                reg_write = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (wait_cnt != '0) result_src = SEL_W'(3);
`endif
            end
            S_EXECR: begin
                alu_src_a = SEL_W'(1);
                alu_op    = ALUOP_W'(2);
            end
            S_EXECI: begin
                alu_src_a = SEL_W'(1);
                alu_src_b = SEL_W'(2);
                alu_op    = ALUOP_W'(2);
                imm       = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SEL_W'(2);
                alu_src_b  = SEL_W'(1);
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = SEL_W'(2);
            end
            S_BRANCH: begin
                alu_src_a = SEL_W'(1);
                alu_op    = ALUOP_W'(1);
                branch    = 1'b1;
                pc_src    = 1'b1;
            end
            S_JALR: begin
                alu_src_a = SEL_W'(2);
                alu_src_b = SEL_W'(1);
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                imm       = 1'b1;
            end
            S_AUIPC: begin
                alu_src_a = SEL_W'(2);
                alu_src_b = SEL_W'(2);
            end
            S_LUI: begin
                alu_src_a = SEL_W'(3);
                alu_src_b = SEL_W'(2);
            end
            S_TRAP: halt = 1'b1;
`ifdef CTRL_MULDIV_EN
            S_MULDIV: md_start = (wait_cnt == '0);
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// state path, and per-state output values come from a lookup table.
module tb_multicycle_ctrl;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned TIMEOUT = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7_0;
    logic               mem_ready;
    logic               md_done;
    logic               pc_write, ir_write, pc_src, reg_write, imm, mem_write, branch;
    logic               mem_req, md_start, halt;
    logic [1:0]         adr_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [SEL_W-1:0]   alu_src_a, alu_src_b, result_src;
    logic [1:0]         trap_cause;
    logic [3:0]         state_o;

    int checks = 0;
    int errors = 0;

    typedef logic [22:0] ovec_t;
    ovec_t obs;
    assign obs = {pc_write, ir_write, pc_src, reg_write, imm, mem_write, branch,
                  mem_req, md_start, halt, adr_src, alu_op, alu_src_a, alu_src_b, result_src};

    always #5 clk = ~clk;

    multicycle_ctrl #(.SEL_W(SEL_W), .ALUOP_W(ALUOP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7_0(funct7_0),
        .mem_ready(mem_ready), .md_done(md_done),
        .pc_write(pc_write), .ir_write(ir_write), .pc_src(pc_src), .reg_write(reg_write),
        .imm(imm), .mem_write(mem_write), .branch(branch), .mem_req(mem_req),
        .md_start(md_start), .adr_src(adr_src), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .halt(halt),
        .trap_cause(trap_cause), .state_o(state_o)
    );

    // Expected path: state number, inputs to apply, and md flags per cycle
    int st_q[$];
    bit mr_q[$], md_q[$], mdf_q[$], mdr_q[$];

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic ovec_t exp_vec(int st, bit mr, bit mdf, bit mdr);
        bit pcw = 0, irw = 0, pcs = 0, rw = 0, im = 0, mw = 0, br = 0, rq = 0, mds = 0, hl = 0;
        int adr = 0, aop = 0, sa = 0, sb = 0, rs = 0;
        case (st)
            0:  begin rq = 1; sb = 1; pcw = mr; irw = mr; end
            1:  begin sa = 2; sb = 2; end
            2:  begin sa = 1; sb = 2; end
            3:  begin adr = 1; rq = 1; end
            4:  begin rw = 1; rs = 1; end
            5:  begin adr = 1; rq = 1; mw = 1; end
            6:  begin sa = 1; aop = 2; end
            7:  begin rw = 1; rs = mdr ? 3 : 0; end
            8:  begin sa = 1; aop = 2; sb = 2; im = 1; end
            9:  begin sa = 2; sb = 1; pcw = 1; rw = 1; rs = 2; end
            10: begin sa = 1; aop = 1; br = 1; pcs = 1; end
            11: begin sa = 2; sb = 1; pcw = 1; pcs = 1; im = 1; end
            12: begin sa = 2; sb = 2; end
            13: begin sa = 3; sb = 2; end
            14: hl = 1;
            15: mds = mdf;
            default: ;
        endcase
        return {pcw, irw, pcs, rw, im, mw, br, rq, mds, hl,
                2'(adr), 2'(aop), 3'(sa), 3'(sb), 3'(rs)};
    endfunction

    function automatic void push(int s, bit m, bit d, bit f, bit r);
        st_q.push_back(s); mr_q.push_back(m); md_q.push_back(d);
        mdf_q.push_back(f); mdr_q.push_back(r);
    endfunction

    // n cycles of mem_ready=0, then ready; returns 1 if the wait times out
    function automatic bit push_wait(int s, int n);
        for (int i = 0; i < n && i < TIMEOUT; i++) push(s, 1'b0, rb(), 1'b0, 1'b0);
        if (n >= TIMEOUT) begin
            push(14, rb(), rb(), 1'b0, 1'b0);
            return 1'b1;
        end
        push(s, 1'b1, rb(), 1'b0, 1'b0);
        return 1'b0;
    endfunction

    // Returns expected trap cause, or -1 when the instruction completes
    function automatic int build(logic [6:0] o, bit f7, int fw, int mw, int mdw);
        st_q.delete(); mr_q.delete(); md_q.delete(); mdf_q.delete(); mdr_q.delete();
        if (push_wait(0, fw)) return 2;
        push(1, rb(), rb(), 1'b0, 1'b0);
        case (o)
            7'b0000011: begin
                push(2, rb(), rb(), 1'b0, 1'b0);
                if (push_wait(3, mw)) return 2;
                push(4, rb(), rb(), 1'b0, 1'b0);
            end
            7'b0100011: begin
                push(2, rb(), rb(), 1'b0, 1'b0);
                if (push_wait(5, mw)) return 2;
            end
            7'b0110011: begin
`ifdef CTRL_MULDIV_EN
                if (f7) begin
                    for (int i = 0; i < mdw; i++) push(15, rb(), 1'b0, i == 0, 1'b0);
                    push(15, rb(), 1'b1, mdw == 0, 1'b0);
                    push(7, rb(), rb(), 1'b0, 1'b1);
                end else begin
                    push(6, rb(), rb(), 1'b0, 1'b0);
                    push(7, rb(), rb(), 1'b0, 1'b0);
                end
`else
                push(6, rb(), rb(), 1'b0, 1'b0);
                push(7, rb(), rb(), 1'b0, 1'b0);
`endif
            end
            7'b0010011: begin push(8, rb(), rb(), 1'b0, 1'b0); push(7, rb(), rb(), 1'b0, 1'b0); end
            7'b1101111: push(9, rb(), rb(), 1'b0, 1'b0);
            7'b1100011: push(10, rb(), rb(), 1'b0, 1'b0);
            7'b1100111: begin push(11, rb(), rb(), 1'b0, 1'b0); push(7, rb(), rb(), 1'b0, 1'b0); end
            7'b0010111: begin push(12, rb(), rb(), 1'b0, 1'b0); push(7, rb(), rb(), 1'b0, 1'b0); end
            7'b0110111: begin push(13, rb(), rb(), 1'b0, 1'b0); push(7, rb(), rb(), 1'b0, 1'b0); end
            7'b1110011: begin push(14, rb(), rb(), 1'b0, 1'b0); return 1; end
            default:    begin push(14, rb(), rb(), 1'b0, 1'b0); return 0; end
        endcase
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, o, e, $time);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; mem_ready = rb(); md_done = rb();
        @(posedge clk); #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        mem_ready = 1'b0; #1;
        chk("rst_out_mr0", 32'(obs), 32'(exp_vec(0, 1'b0, 1'b0, 1'b0)));
        mem_ready = 1'b1; #1;
        chk("rst_out_mr1", 32'(obs), 32'(exp_vec(0, 1'b1, 1'b0, 1'b0)));
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic run(input logic [6:0] o, input bit f7, input int fw, input int mw,
                       input int mdw, input int hold);
        int c;
        op = o; funct7_0 = f7; funct3 = 3'($urandom);
        c = build(o, f7, fw, mw, mdw);
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ready = mr_q[i]; md_done = md_q[i]; #1;
            chk("state", 32'(state_o), 32'(st_q[i]));
            chk("outputs", 32'(obs), 32'(exp_vec(st_q[i], mr_q[i], mdf_q[i], mdr_q[i])));
            if (st_q[i] == 14) chk("trap_cause", 32'(trap_cause), 32'(c));
            @(posedge clk); #1;
        end
        if (c >= 0) begin
            for (int i = 0; i < hold; i++) begin
                mem_ready = rb(); md_done = rb(); #1;
                chk("trap_state", 32'(state_o), 32'd14);
                chk("trap_outputs", 32'(obs), 32'(exp_vec(14, 1'b0, 1'b0, 1'b0)));
                chk("trap_cause_held", 32'(trap_cause), 32'(c));
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [0:10];
        logic [6:0] o;
        int k, fw, mw;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011,
                7'b1100111, 7'b0010111, 7'b0110111, 7'b1110011, 7'b0000000};
        resetn = 1'b0; op = '0; funct3 = '0; funct7_0 = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
        do_reset();

        run(7'b0110011, 1'b0, 0, 0, 0, 0);   // add, no waits
        run(7'b0000011, 1'b0, 0, 3, 0, 0);   // load, 3 wait cycles in MEMREAD
        run(7'b0100011, 1'b0, 1, 2, 0, 0);   // store with waits
        run(7'b0110011, 1'b0, 3, 0, 0, 0);   // ready on the last allowed cycle
        run(7'b0010011, 1'b0, 4, 0, 0, 5);   // FETCH timeout
        run(7'b0000011, 1'b0, 0, 4, 0, 3);   // MEMREAD timeout
        run(7'b0100011, 1'b0, 0, 4, 0, 3);   // MEMWR timeout
        run(7'b1110011, 1'b0, 0, 0, 0, 20);  // ECALL/EBREAK
        run(7'b1111111, 1'b0, 0, 0, 0, 20);  // illegal opcode
        run(7'b0110011, 1'b1, 0, 0, 5, 0);   // M-extension op
        run(7'b0110011, 1'b1, 0, 0, 0, 0);
        run(7'b1101111, 1'b0, 0, 0, 0, 0);
        run(7'b1100011, 1'b0, 0, 0, 0, 0);
        run(7'b1100111, 1'b0, 0, 0, 0, 0);
        run(7'b0010111, 1'b0, 0, 0, 0, 0);
        run(7'b0110111, 1'b0, 0, 0, 0, 0);

        // reset in the middle of a FETCH wait must clear the wait counter
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1; chk("prewait_state", 32'(state_o), 32'd0);
            @(posedge clk); #1;
        end
        do_reset();
        run(7'b0110011, 1'b0, 3, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 11));
            if (k == 11) o = 7'($urandom);
            else o = ops[k];
            fw = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
            run(o, rb(), fw, mw, int'($urandom_range(0, 6)), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
